// File: rtl/cache_mem_responder.sv
// Cache-side responder: serves line/word reads and writebacks from a word-wide
// synchronous RAM port, one transaction at a time, with optional idle gaps between beats.
module cache_mem_responder #(
    parameter int MEM_AW   = 16,
    parameter int BEAT_GAP = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [2:0]        rd_type,
    input  logic [31:0]       rd_addr,
    output logic              rd_rdy,
    output logic              ret_valid,
    output logic              ret_last,
    output logic [31:0]       ret_data,
    input  logic              wr_req,
    input  logic [2:0]        wr_type,
    input  logic [31:0]       wr_addr,
    input  logic [3:0]        wr_wstrb,
    input  logic [127:0]      wr_data,
    output logic              wr_rdy,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RD     = 2'd1;
    localparam logic [1:0] ST_WR     = 2'd2;
    localparam logic [2:0] TYPE_LINE = 3'b100;
    localparam logic [2:0] GAP       = 3'(BEAT_GAP);

    logic [1:0]        state_q, state_d;
    logic              line_q, line_d;
    logic [MEM_AW-1:0] base_q, base_d;
    logic [127:0]      data_q, data_d;
    logic [3:0]        strb_q, strb_d;
    logic [1:0]        k_q, k_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [2:0]        gap_q, gap_d;
    logic              mem_en_q, mem_en_d;
    logic [3:0]        mem_we_q, mem_we_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_last_q, mem_last_d;
    logic              ret_valid_q, ret_valid_d;
    logic              ret_last_q, ret_last_d;

    logic              issue, iss_line, iss_wr;
    logic [1:0]        iss_k;
    logic [MEM_AW-1:0] iss_base;
    logic [127:0]      iss_data;
    logic [3:0]        iss_strb;

    // Byte offsets and address bits above the RAM size are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rd_addr[31:MEM_AW+2], rd_addr[1:0],
                                wr_addr[31:MEM_AW+2], wr_addr[1:0]};

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        base_d      = base_q;
        data_d      = data_q;
        strb_d      = strb_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 4'h0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_last_d  = 1'b0;
        issue       = 1'b0;
        iss_line    = line_q;
        iss_wr      = (state_q == ST_WR);
        iss_k       = k_q;
        iss_base    = base_q;
        iss_data    = data_q;
        iss_strb    = strb_q;
        // Read data arrives the cycle after a read issue; tag it with the issue's last flag.
        ret_valid_d = (state_q == ST_RD) && mem_en_q;
        ret_last_d  = (state_q == ST_RD) && mem_en_q && mem_last_q;

        case (state_q)
            ST_IDLE: begin
                if (wr_req) begin
                    state_d  = ST_WR;
                    line_d   = (wr_type == TYPE_LINE);
                    base_d   = wr_addr[MEM_AW+1:2];
                    data_d   = wr_data;
                    strb_d   = wr_wstrb;
                    cnt_d    = line_d ? 2'd3 : 2'd0;
                    issue    = 1'b1;
                    iss_wr   = 1'b1;
                    iss_line = line_d;
                    iss_k    = 2'd0;
                    iss_base = base_d;
                    iss_data = wr_data;
                    iss_strb = wr_wstrb;
                end else if (rd_req) begin
                    state_d  = ST_RD;
                    line_d   = (rd_type == TYPE_LINE);
                    base_d   = rd_addr[MEM_AW+1:2];
                    cnt_d    = line_d ? 2'd3 : 2'd0;
                    issue    = 1'b1;
                    iss_wr   = 1'b0;
                    iss_line = line_d;
                    iss_k    = 2'd0;
                    iss_base = base_d;
                end
            end
            ST_RD, ST_WR: begin
                if (gap_q != 3'd0) begin
                    gap_d = gap_q - 3'd1;
                end else if (cnt_q != 2'd0) begin
                    issue = 1'b1;
                    cnt_d = cnt_q - 2'd1;
                end
                if ((state_q == ST_RD) ? ret_last_q : (mem_en_q && mem_last_q)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            mem_en_d    = 1'b1;
            mem_last_d  = !iss_line || (iss_k == 2'd3);
            mem_addr_d  = iss_line ? {iss_base[MEM_AW-1:2], iss_k} : iss_base;
            mem_we_d    = !iss_wr ? 4'h0 : (iss_line ? 4'hf : iss_strb);
            mem_wdata_d = iss_line ? iss_data[{iss_k, 5'd0} +: 32] : iss_data[31:0];
            k_d         = iss_k + 2'd1;
            gap_d       = GAP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            line_q      <= 1'b0;
            base_q      <= '0;
            data_q      <= '0;
            strb_q      <= 4'h0;
            k_q         <= 2'd0;
            cnt_q       <= 2'd0;
            gap_q       <= 3'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 4'h0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            mem_last_q  <= 1'b0;
            ret_valid_q <= 1'b0;
            ret_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            base_q      <= base_d;
            data_q      <= data_d;
            strb_q      <= strb_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_last_q  <= mem_last_d;
            ret_valid_q <= ret_valid_d;
            ret_last_q  <= ret_last_d;
        end
    end

    assign wr_rdy    = (state_q == ST_IDLE);
    assign rd_rdy    = (state_q == ST_IDLE) && !wr_req;
    assign ret_valid = ret_valid_q;
    assign ret_last  = ret_last_q;
    assign ret_data  = mem_rdata;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
